mc_ctrl: RTL and testbench

- Multi-cycle MIPS control unit. Drives the ALU's `alu_ctrl` input and consumes its `zero` output, completing the ALU interface from the driving side.
- Sequences fetch / decode / execute / memory / writeback for the datapath: PC, IR, register file, unified memory, and operand muxes.
- Moore FSM plus a retired-instruction counter.
- ALU op codes are the shared header macros: `AND`=3'b000, `OR`=3'b001, `ADD`=3'b010, `SUB`=3'b110, `SLT`=3'b111, `OFF`=3'b100.

---
 rtl/mc_ctrl_if.sv | 38 +++
 rtl/mc_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_mc_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath.
// The controller drives ALU op, mux selects and strobes; the datapath
// returns the decoded IR fields and the ALU zero flag.
interface mc_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
  logic [2:0]       alu_ctrl;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       pc_src;
  logic             pc_en;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             instr_done;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, funct, zero,
    output alu_ctrl, alu_src_a, alu_src_b, pc_src, pc_en, i_or_d,
           mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           instr_done, instr_count
  );

  modport slave (
    output opcode, funct, zero,
    input  alu_ctrl, alu_src_a, alu_src_b, pc_src, pc_en, i_or_d,
           mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           instr_done, instr_count
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch / decode /
// execute / memory / writeback, plus a retired-instruction counter.
// Per-state outputs are registered from the next-state decode; only
// pc_en in BRANCH (taken on zero) and instr_done in DECODE (unknown
// opcode) are combinational, because their inputs are only valid in the
// state itself. rst forces every output to its idle value.
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic     clk,
  input  logic     rst,
  mc_ctrl_if.master bus
);

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_OFF = 3'b100;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXECUTE, S_ALU_WB, S_ADDI_EXEC, S_ADDI_WB, S_BRANCH, S_JUMP
  } state_t;

  typedef struct packed {
    logic [2:0] alu_ctrl;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       instr_done;
  } ctrl_t;

  // R-type funct to ALU op; anything unrecognised turns the ALU off.
  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100000: return ALU_ADD;
      6'b100010: return ALU_SUB;
      6'b100100: return ALU_AND;
      6'b100101: return ALU_OR;
      6'b101010: return ALU_SLT;
      default:   return ALU_OFF;
    endcase
  endfunction

  function automatic logic opcode_known(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

  function automatic state_t next_state(input state_t s, input logic [5:0] op);
    case (s)
      S_FETCH:     return S_DECODE;
      S_DECODE:
        case (op)
          OP_R:          return S_EXECUTE;
          OP_LW, OP_SW:  return S_MEM_ADDR;
          OP_ADDI:       return S_ADDI_EXEC;
          OP_BEQ:        return S_BRANCH;
          OP_J:          return S_JUMP;
          default:       return S_FETCH;
        endcase
      S_MEM_ADDR:  return (op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  return S_MEM_WB;
      S_EXECUTE:   return S_ALU_WB;
      S_ADDI_EXEC: return S_ADDI_WB;
      default:     return S_FETCH;
    endcase
  endfunction

  // Output word for a state; funct only matters for EXECUTE / ALU_WB.
  function automatic ctrl_t state_ctrl(input state_t s, input logic [5:0] f);
    ctrl_t c;
    // NOTE: every field gets an idle default before the case so no path
    // leaves a field unassigned.
    c          = '0;
    c.alu_ctrl = ALU_OFF;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_b = 2'd1;
        c.alu_ctrl  = ALU_ADD;
        c.pc_en     = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_b = 2'd3;
        c.alu_ctrl  = ALU_ADD;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd2;
        c.alu_ctrl  = ALU_ADD;
      end
      S_MEM_READ: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        c.mem_write  = 1'b1;
        c.i_or_d     = 1'b1;
        c.instr_done = 1'b1;
      end
      S_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_ctrl  = funct_alu(f);
      end
      S_ALU_WB: begin
        c.reg_write  = (funct_alu(f) != ALU_OFF);
        c.reg_dst    = 1'b1;
        c.instr_done = 1'b1;
      end
      S_ADDI_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd2;
        c.alu_ctrl  = ALU_ADD;
      end
      S_ADDI_WB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a  = 1'b1;
        c.alu_ctrl   = ALU_SUB;
        c.pc_src     = 2'd1;
        c.instr_done = 1'b1;
      end
      S_JUMP: begin
        c.pc_src     = 2'd2;
        c.pc_en      = 1'b1;
        c.instr_done = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  state_t           state;
  ctrl_t            ctrl_q;
  logic [CNT_W-1:0] count;
  logic             done;

  assign done = !rst && (ctrl_q.instr_done ||
                         (state == S_DECODE && !opcode_known(bus.opcode)));

  // State, registered output word for the state being entered, and counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      state  <= S_FETCH;
      ctrl_q <= state_ctrl(S_FETCH, bus.funct);
      count  <= '0;
    end else begin
      state  <= next_state(state, bus.opcode);
      ctrl_q <= state_ctrl(next_state(state, bus.opcode), bus.funct);
      if (done) count <= count + 1'b1;
    end
  end

  assign bus.alu_ctrl    = rst ? ALU_OFF : ctrl_q.alu_ctrl;
  assign bus.alu_src_a   = !rst && ctrl_q.alu_src_a;
  assign bus.alu_src_b   = rst ? 2'd0 : ctrl_q.alu_src_b;
  assign bus.pc_src      = rst ? 2'd0 : ctrl_q.pc_src;
  assign bus.pc_en       = !rst && (ctrl_q.pc_en || (state == S_BRANCH && bus.zero));
  assign bus.i_or_d      = !rst && ctrl_q.i_or_d;
  assign bus.mem_read    = !rst && ctrl_q.mem_read;
  assign bus.mem_write   = !rst && ctrl_q.mem_write;
  assign bus.ir_write    = !rst && ctrl_q.ir_write;
  assign bus.reg_dst     = !rst && ctrl_q.reg_dst;
  assign bus.mem_to_reg  = !rst && ctrl_q.mem_to_reg;
  assign bus.reg_write   = !rst && ctrl_q.reg_write;
  assign bus.instr_done  = done;
  assign bus.instr_count = count;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle output vectors for each
// instruction class, reset mid-instruction, and counter wrap on a
// narrow-counter instance.
module tb_mc_ctrl;

  // Output vector layout:
  // {alu_ctrl[2:0], alu_src_a, alu_src_b[1:0], pc_src[1:0],
  //  pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
  //  reg_write, instr_done}
  localparam logic [16:0] V_RST     = {3'b100, 1'b0, 2'd0, 2'd0, 9'b000000000};
  localparam logic [16:0] V_FETCH   = {3'b010, 1'b0, 2'd1, 2'd0, 9'b101010000};
  localparam logic [16:0] V_DEC     = {3'b010, 1'b0, 2'd3, 2'd0, 9'b000000000};
  localparam logic [16:0] V_DEC_BAD = {3'b010, 1'b0, 2'd3, 2'd0, 9'b000000001};
  localparam logic [16:0] V_MADDR   = {3'b010, 1'b1, 2'd2, 2'd0, 9'b000000000};
  localparam logic [16:0] V_MREAD   = {3'b100, 1'b0, 2'd0, 2'd0, 9'b011000000};
  localparam logic [16:0] V_MWB     = {3'b100, 1'b0, 2'd0, 2'd0, 9'b000000111};
  localparam logic [16:0] V_MWRITE  = {3'b100, 1'b0, 2'd0, 2'd0, 9'b010100001};
  localparam logic [16:0] V_EX_SLT  = {3'b111, 1'b1, 2'd0, 2'd0, 9'b000000000};
  localparam logic [16:0] V_EX_OFF  = {3'b100, 1'b1, 2'd0, 2'd0, 9'b000000000};
  localparam logic [16:0] V_AWB     = {3'b100, 1'b0, 2'd0, 2'd0, 9'b000001011};
  localparam logic [16:0] V_AWB_BAD = {3'b100, 1'b0, 2'd0, 2'd0, 9'b000001001};
  localparam logic [16:0] V_IEXEC   = {3'b010, 1'b1, 2'd2, 2'd0, 9'b000000000};
  localparam logic [16:0] V_IWB     = {3'b100, 1'b0, 2'd0, 2'd0, 9'b000000011};
  localparam logic [16:0] V_BR_T    = {3'b110, 1'b1, 2'd0, 2'd1, 9'b100000001};
  localparam logic [16:0] V_BR_N    = {3'b110, 1'b1, 2'd0, 2'd1, 9'b000000001};
  localparam logic [16:0] V_JUMP    = {3'b100, 1'b0, 2'd0, 2'd2, 9'b100000001};
  localparam logic [16:0] V_NONE    = '0;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD = 6'b111111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_w = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mc_ctrl_if #(.CNT_W(32)) bus ();
  mc_ctrl_if #(.CNT_W(2))  bus_w ();

  mc_ctrl #(.CNT_W(32)) dut   (.clk(clk), .rst(rst),   .bus(bus));
  mc_ctrl #(.CNT_W(2))  dut_w (.clk(clk), .rst(rst_w), .bus(bus_w));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] snap(input int sel);
    if (sel == 0)
      return {bus.alu_ctrl, bus.alu_src_a, bus.alu_src_b, bus.pc_src,
              bus.pc_en, bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
              bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.instr_done};
    else
      return {bus_w.alu_ctrl, bus_w.alu_src_a, bus_w.alu_src_b, bus_w.pc_src,
              bus_w.pc_en, bus_w.i_or_d, bus_w.mem_read, bus_w.mem_write, bus_w.ir_write,
              bus_w.reg_dst, bus_w.mem_to_reg, bus_w.reg_write, bus_w.instr_done};
  endfunction

  function automatic logic [31:0] count_of(input int sel);
    if (sel == 0) return bus.instr_count;
    else          return {30'd0, bus_w.instr_count};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic [5:0] op, input logic [5:0] fn, input logic z);
    if (sel == 0) begin
      bus.opcode = op; bus.funct = fn; bus.zero = z;
    end else begin
      bus_w.opcode = op; bus_w.funct = fn; bus_w.zero = z;
    end
  endtask

  // Runs one instruction from its FETCH cycle, checking each cycle's
  // outputs, then checks the counter once the instruction has retired.
  task automatic run(input int sel, input string tag, input logic [5:0] op,
                     input logic [5:0] fn, input logic z, input int n,
                     input logic [16:0] v0, input logic [16:0] v1,
                     input logic [16:0] v2, input logic [16:0] v3,
                     input logic [16:0] v4, input logic [31:0] cnt_exp);
    logic [16:0] v [5];
    v = '{v0, v1, v2, v3, v4};
    drive(sel, op, fn, z);
    #1;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_c%0d", tag, i), {15'd0, snap(sel)}, {15'd0, v[i]});
      step();
    end
    check($sformatf("%s_cnt", tag), count_of(sel), cnt_exp);
  endtask

  initial begin
    drive(0, OP_R, 6'd0, 1'b0);
    drive(1, OP_J, 6'd0, 1'b0);

    // Reset state on both instances.
    step(); step();
    check("rst_vec", {15'd0, snap(0)}, {15'd0, V_RST});
    check("rst_vec_w", {15'd0, snap(1)}, {15'd0, V_RST});

    // Release, walk an LW into MEM_READ, then reset for 3 cycles.
    rst = 1'b0;
    drive(0, OP_LW, 6'd0, 1'b0);
    #1;
    check("lw0_fetch", {15'd0, snap(0)}, {15'd0, V_FETCH});
    step(); check("lw0_dec",   {15'd0, snap(0)}, {15'd0, V_DEC});
    step(); check("lw0_maddr", {15'd0, snap(0)}, {15'd0, V_MADDR});
    step(); check("lw0_mread", {15'd0, snap(0)}, {15'd0, V_MREAD});
    rst = 1'b1;
    #1;
    check("midrst_c0", {15'd0, snap(0)}, {15'd0, V_RST});
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("midrst_c%0d", i), {15'd0, snap(0)}, {15'd0, V_RST});
    end
    rst = 1'b0;
    #1;
    check("post_rst_fetch", {15'd0, snap(0)}, {15'd0, V_FETCH});
    check("post_rst_cnt", count_of(0), 32'd0);

    // zero held high in non-branch instructions must have no effect.
    run(0, "slt",   OP_R,    6'b101010, 1'b1, 4, V_FETCH, V_DEC, V_EX_SLT, V_AWB, V_NONE, 32'd1);
    run(0, "lw",    OP_LW,   6'd0,      1'b1, 5, V_FETCH, V_DEC, V_MADDR, V_MREAD, V_MWB, 32'd2);
    run(0, "sw",    OP_SW,   6'd0,      1'b0, 4, V_FETCH, V_DEC, V_MADDR, V_MWRITE, V_NONE, 32'd3);
    run(0, "beq_t", OP_BEQ,  6'd0,      1'b1, 3, V_FETCH, V_DEC, V_BR_T, V_NONE, V_NONE, 32'd4);
    run(0, "beq_n", OP_BEQ,  6'd0,      1'b0, 3, V_FETCH, V_DEC, V_BR_N, V_NONE, V_NONE, 32'd5);
    run(0, "badop", OP_BAD,  6'd0,      1'b0, 2, V_FETCH, V_DEC_BAD, V_NONE, V_NONE, V_NONE, 32'd6);
    run(0, "badfn", OP_R,    6'b000000, 1'b0, 4, V_FETCH, V_DEC, V_EX_OFF, V_AWB_BAD, V_NONE, 32'd7);
    run(0, "addi",  OP_ADDI, 6'd0,      1'b1, 4, V_FETCH, V_DEC, V_IEXEC, V_IWB, V_NONE, 32'd8);
    check("next_fetch", {15'd0, snap(0)}, {15'd0, V_FETCH});

    // Counter wrap on the 2-bit instance: 1, 2, 3, 0, 1.
    rst_w = 1'b0;
    for (int k = 1; k <= 5; k++)
      run(1, $sformatf("j%0d", k), OP_J, 6'd0, 1'b0, 3,
          V_FETCH, V_DEC, V_JUMP, V_NONE, V_NONE, 32'(k % 4));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
